center_derivative_core: RTL and testbench

- Streaming central-difference derivative estimator for a sampled input word.
- Every clock it produces y[k] = x[k] - x[k-2], where x[k] is the sample captured at edge k.
- This is the 2-sample-spaced difference; the /2 scaling is omitted so the result stays exact.
- Sits in the signal-processing datapath after the sampler and feeds downstream slope/edge logic with a registered, sign-extended result.

---
 rtl/center_derivative_core.sv | 68 ++++++
 tb/tb_center_derivative_core.sv | 117 +++++++++++
 2 files changed

// File: rtl/center_derivative_core.sv
// Streaming 2-spaced difference estimator: out = x[k] - x[k-2], registered and sign-extended.
// Output is held at zero until two samples of history have been captured after reset.
module center_derivative_core #(
   parameter int Nbits = 2,
   parameter int OUT_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [Nbits:0]   IN_center_der,
   output logic [OUT_W-1:0] out_center_der
);

   if (OUT_W < Nbits + 2) begin : g_width_check
      $error("center_derivative_core: OUT_W must be at least Nbits+2");
   end

   logic [Nbits:0]          d1_q, d1_d;
   logic [Nbits:0]          d2_q, d2_d;
   logic [1:0]              fill_q, fill_d;
   logic [OUT_W-1:0]        out_q, out_d;
   logic signed [Nbits+1:0] diff_s;

   // Next-state: difference against the x[k-2] tap, warm-up gating, tap shift, fill saturation
   always_comb begin
      diff_s = '0;
      out_d  = '0;
      fill_d = fill_q;
      d1_d   = IN_center_der;
      d2_d   = d1_q;
      diff_s = signed'({1'b0, IN_center_der}) - signed'({1'b0, d2_q});
      case (fill_q)
         2'd0: begin
            out_d  = '0;
            fill_d = 2'd1;
         end
         2'd1: begin
            out_d  = '0;
            fill_d = 2'd2;
         end
         2'd2: begin
            out_d  = OUT_W'(diff_s);
            fill_d = 2'd2;
         end
         default: begin
            out_d  = '0;
            fill_d = 2'd0;
         end
      endcase
   end

   // State registers; reset empties the history so warm-up restarts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d1_q   <= '0;
         d2_q   <= '0;
         fill_q <= 2'd0;
         out_q  <= '0;
      end else begin
         d1_q   <= d1_d;
         d2_q   <= d2_d;
         fill_q <= fill_d;
         out_q  <= out_d;
      end
   end

   assign out_center_der = out_q;

endmodule

// File: tb/tb_center_derivative_core.sv
// Directed bench for center_derivative_core with default parameters (3-bit samples, 10-bit output).
module tb_center_derivative_core;

   logic       clk;
   logic       rst_n;
   logic [2:0] in_s;
   logic [9:0] out_s;
   int         checks;
   int         failures;

   center_derivative_core #(.Nbits(2), .OUT_W(10)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .IN_center_der  (in_s),
      .out_center_der (out_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [9:0] exp);
      checks++;
      assert (out_s === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, out_s, exp);
      end
   endtask

   task automatic step(input logic [2:0] s, input logic [9:0] exp, input string tag);
      in_s = s;
      @(posedge clk);
      #1;
      check(tag, exp);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      in_s     = 3'd5;

      // Reset held with clock running
      repeat (3) begin
         @(posedge clk);
         #1;
         check("reset_hold", 10'h000);
      end
      rst_n = 1'b1;

      // Warm-up then step up
      step(3'd0, 10'h000, "warm0");
      step(3'd2, 10'h000, "warm1");
      step(3'd2, 10'h002, "stepup_a");
      step(3'd2, 10'h000, "stepup_b");
      step(3'd2, 10'h000, "stepup_c");

      // Step down
      step(3'd2, 10'h000, "stepdn_0");
      step(3'd2, 10'h000, "stepdn_1");
      step(3'd2, 10'h000, "stepdn_2");
      step(3'd1, 10'h3FF, "stepdn_3");
      step(3'd1, 10'h3FF, "stepdn_4");
      step(3'd1, 10'h000, "stepdn_5");

      // Reset between edges, then extremes
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_async_a", 10'h000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(3'd0, 10'h000, "ext_0");
      step(3'd0, 10'h000, "ext_1");
      step(3'd7, 10'h007, "ext_2");
      step(3'd7, 10'h007, "ext_3");
      step(3'd0, 10'h3F9, "ext_4");
      step(3'd0, 10'h3F9, "ext_5");

      // Mid-cycle reset clears a nonzero output without an edge
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_async_b", 10'h000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Period-2 input cancels in the 2-spaced difference
      step(3'd0, 10'h000, "alt_0");
      step(3'd7, 10'h000, "alt_1");
      step(3'd0, 10'h000, "alt_2");
      step(3'd7, 10'h000, "alt_3");
      step(3'd0, 10'h000, "alt_4");
      step(3'd7, 10'h000, "alt_5");

      // Ramp continuing from the alternating history (d1=7, d2=0)
      step(3'd1, 10'h001, "ramp_0");
      step(3'd3, 10'h3FC, "ramp_1");
      step(3'd5, 10'h004, "ramp_2");
      step(3'd7, 10'h004, "ramp_3");

      // One-cycle reset, history must restart
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("reset_mid", 10'h000);
      rst_n = 1'b1;
      step(3'd4, 10'h000, "post_0");
      step(3'd4, 10'h000, "post_1");
      step(3'd6, 10'h002, "post_2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
